blit_read_fifo: RTL and testbench

// Read-side counterpart of the blitter write FIFO. Accepts source read addresses from the blitter,

---
 rtl/blit_read_fifo_if.sv | 27 ++
 rtl/blit_read_fifo.sv | 129 ++++++++++++
 tb/tb_blit_read_fifo.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blit_read_fifo_if.sv
// rtl/blit_read_fifo_if.sv - blitter read FIFO bus: address push, memory req/ack/return, data pop
// slave is the FIFO side; master is the blitter and memory side.
interface blit_read_fifo_if;
  logic        in_read;
  logic [25:0] in_addr;
  logic        fifo_full;
  logic        mem_req;
  logic [25:0] mem_addr;
  logic        mem_ack;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        idle;
  logic        err;

  modport slave (
    input  in_read, in_addr, mem_ack, mem_rdata_valid, mem_rdata, out_ready,
    output fifo_full, mem_req, mem_addr, out_valid, out_data, idle, err
  );

  modport master (
    output in_read, in_addr, mem_ack, mem_rdata_valid, mem_rdata, out_ready,
    input  fifo_full, mem_req, mem_addr, out_valid, out_data, idle, err
  );
endinterface

// File: rtl/blit_read_fifo.sv
// rtl/blit_read_fifo.sv - credit-limited read FIFO: address queue -> mem req/ack -> FWFT data queue
// A read is claimed when loaded into the request register and released when its data is popped.
module blit_read_fifo #(
  parameter int ADDR_DEPTH  = 16,
  parameter int DATA_DEPTH  = 16,
  parameter int FULL_MARGIN = 4
) (
  input logic            clock,
  input logic            reset,
  blit_read_fifo_if.slave bus
);
  localparam int AW = $clog2(ADDR_DEPTH);
  localparam int DW = $clog2(DATA_DEPTH);
  localparam logic [AW:0] ADDR_CAP = (AW+1)'(ADDR_DEPTH);
  localparam logic [AW:0] MARGIN   = (AW+1)'(FULL_MARGIN);
  localparam logic [DW:0] DATA_CAP = (DW+1)'(DATA_DEPTH);

  typedef enum logic {REQ_IDLE, REQ_BUSY} req_state_e;

  logic [25:0]   addr_mem_q [ADDR_DEPTH];
  logic [AW-1:0] addr_wr_ptr_q, addr_rd_ptr_q;
  logic [AW:0]   addr_count_q, addr_count_d;

  logic [31:0]   data_mem_q [DATA_DEPTH];
  logic [DW-1:0] data_wr_ptr_q, data_rd_ptr_q;
  logic [DW:0]   data_count_q, data_count_d;
  logic [DW:0]   claims_q, claims_d;

  req_state_e    req_state_q, req_state_d;
  logic [25:0]   req_addr_q, req_addr_d;
  logic          err_q;

  logic push_ok, push_drop, can_load, load, ret_ok, ret_stray, pop;

  assign push_ok   = bus.in_read && (addr_count_q != ADDR_CAP);
  assign push_drop = bus.in_read && (addr_count_q == ADDR_CAP);
  assign can_load  = (addr_count_q != '0) && (claims_q < DATA_CAP);
  assign pop       = (data_count_q != '0) && bus.out_ready;
  // Returns are only legal while some claimed read has not yet landed in the data queue.
  assign ret_ok    = bus.mem_rdata_valid && (claims_q > data_count_q);
  assign ret_stray = bus.mem_rdata_valid && (claims_q <= data_count_q);

  always_comb begin
    req_state_d = req_state_q;
    req_addr_d  = req_addr_q;
    load        = 1'b0;
    case (req_state_q)
      REQ_IDLE: begin
        if (can_load) begin
          load        = 1'b1;
          req_state_d = REQ_BUSY;
          req_addr_d  = addr_mem_q[addr_rd_ptr_q];
        end
      end
      REQ_BUSY: begin
        if (bus.mem_ack) begin
          if (can_load) begin
            load       = 1'b1;
            req_addr_d = addr_mem_q[addr_rd_ptr_q];
          end else begin
            req_state_d = REQ_IDLE;
          end
        end
      end
      default: req_state_d = REQ_IDLE;
    endcase
  end

  always_comb begin
    addr_count_d = addr_count_q;
    claims_d     = claims_q;
    data_count_d = data_count_q;
    case ({push_ok, load})
      2'b10:   addr_count_d = addr_count_q + 1'b1;
      2'b01:   addr_count_d = addr_count_q - 1'b1;
      default: addr_count_d = addr_count_q;
    endcase
    case ({load, pop})
      2'b10:   claims_d = claims_q + 1'b1;
      2'b01:   claims_d = claims_q - 1'b1;
      default: claims_d = claims_q;
    endcase
    case ({ret_ok, pop})
      2'b10:   data_count_d = data_count_q + 1'b1;
      2'b01:   data_count_d = data_count_q - 1'b1;
      default: data_count_d = data_count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_state_q   <= REQ_IDLE;
      req_addr_q    <= '0;
      addr_wr_ptr_q <= '0;
      addr_rd_ptr_q <= '0;
      addr_count_q  <= '0;
      data_wr_ptr_q <= '0;
      data_rd_ptr_q <= '0;
      data_count_q  <= '0;
      claims_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      req_state_q  <= req_state_d;
      req_addr_q   <= req_addr_d;
      addr_count_q <= addr_count_d;
      data_count_q <= data_count_d;
      claims_q     <= claims_d;
      err_q        <= err_q | push_drop | ret_stray;
      if (push_ok) addr_wr_ptr_q <= addr_wr_ptr_q + AW'(1);
      if (load)    addr_rd_ptr_q <= addr_rd_ptr_q + AW'(1);
      if (ret_ok)  data_wr_ptr_q <= data_wr_ptr_q + DW'(1);
      if (pop)     data_rd_ptr_q <= data_rd_ptr_q + DW'(1);
    end
  end

  // Storage arrays carry no reset; validity is tracked entirely by the counts.
  always_ff @(posedge clock) begin
    if (push_ok) addr_mem_q[addr_wr_ptr_q] <= bus.in_addr;
    if (ret_ok)  data_mem_q[data_wr_ptr_q] <= bus.mem_rdata;
  end

  assign bus.fifo_full = (ADDR_CAP - addr_count_q) < MARGIN;
  assign bus.mem_req   = (req_state_q == REQ_BUSY);
  assign bus.mem_addr  = req_addr_q;
  assign bus.out_valid = (data_count_q != '0);
  assign bus.out_data  = data_mem_q[data_rd_ptr_q];
  assign bus.idle      = (addr_count_q == '0) && (req_state_q == REQ_IDLE) && (claims_q == '0);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_blit_read_fifo.sv
// tb/tb_blit_read_fifo.sv - self-checking bench for blit_read_fifo with an in-order memory model
// Expected data stream is derived from the accepted push addresses, independent of DUT internals.
module tb_blit_read_fifo;
  logic clock = 1'b0;
  logic reset = 1'b1;
  blit_read_fifo_if bus();

  blit_read_fifo #(.ADDR_DEPTH(16), .DATA_DEPTH(16), .FULL_MARGIN(4)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int ack_cnt = 0;
  bit resp_en = 1'b0;
  int resp_rate = 100;
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] fdata(input logic [25:0] a);
    return {a, 6'h15} ^ 32'hC3A5_0000;
  endfunction

  function automatic logic [25:0] rand_addr();
    return 26'($urandom()) & 26'h3FF_FFFC;
  endfunction

  // Memory model: acknowledged addresses return their data in order, optionally throttled.
  always @(posedge clock) begin
    if (reset) pend.delete();
    else if (bus.mem_req && bus.mem_ack) begin
      pend.push_back(fdata(bus.mem_addr));
      ack_cnt++;
    end
    if (resp_en) begin
      #1;
      if (pend.size() > 0 && $urandom_range(99) < resp_rate) begin
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = pend.pop_front();
      end else begin
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata       = '0;
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    resp_en             = 1'b0;
    bus.in_read         = 1'b0;
    bus.in_addr         = '0;
    bus.mem_ack         = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
    bus.out_ready       = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    ack_cnt = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    bus.in_read   = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b1;
    resp_rate     = 100;
    resp_en       = 1'b1;
    while ((exp_q.size() > 0 || !bus.idle) && n < budget) begin
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL %s_extra got %h want no data", tag, bus.out_data);
        else if (bus.out_data !== exp_q[0]) $display("FAIL %s_data got %h want %h", tag, bus.out_data, exp_q[0]);
        else passed++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      step();
      n++;
    end
    bus.out_ready = 1'b0;
    bus.mem_ack   = 1'b0;
    checks++;
    if (exp_q.size() != 0 || bus.idle !== 1'b1)
      $display("FAIL %s_drain got left=%0d idle=%b want left=0 idle=1", tag, exp_q.size(), bus.idle);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req got %b want 0", bus.mem_req); else passed++;
    checks++; if (bus.mem_addr !== 26'h0) $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); else passed++;
    checks++; if (bus.fifo_full !== 1'b0) $display("FAIL rst_fifo_full got %b want 0", bus.fifo_full); else passed++;
    checks++; if (bus.idle !== 1'b1) $display("FAIL rst_idle got %b want 1", bus.idle); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL rst_err got %b want 0", bus.err); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    bus.in_read = 1'b1; bus.in_addr = 26'h0000100;
    step();
    bus.in_read = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL single_latency got mem_req=%b want 0", bus.mem_req); else passed++;
    step();
    checks++; if (bus.mem_req !== 1'b1) $display("FAIL single_req got %b want 1", bus.mem_req); else passed++;
    checks++; if (bus.mem_addr !== 26'h0000100) $display("FAIL single_addr got %h want 0000100", bus.mem_addr); else passed++;
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || bus.idle !== 1'b0)
      $display("FAIL single_after_ack got req=%b idle=%b want req=0 idle=0", bus.mem_req, bus.idle); else passed++;
    step();
    step();
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_early got out_valid=%b want 0", bus.out_valid); else passed++;
    step();
    bus.mem_rdata_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEADBEEF)
      $display("FAIL single_data got v=%b d=%h want v=1 d=deadbeef", bus.out_valid, bus.out_data); else passed++;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.idle !== 1'b1 || bus.err !== 1'b0)
      $display("FAIL single_pop got v=%b idle=%b err=%b want 0 1 0", bus.out_valid, bus.idle, bus.err); else passed++;
  endtask

  task automatic test_credit_limit();
    logic [25:0] a;
    do_reset();
    resp_rate = 100; resp_en = 1'b1; bus.mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = rand_addr();
      exp_q.push_back(fdata(a));
      bus.in_read = 1'b1; bus.in_addr = a;
      step();
    end
    bus.in_read = 1'b0;
    repeat (10) step();
    checks++; if (ack_cnt != 16) $display("FAIL credit_acks got %0d want 16", ack_cnt); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL credit_req got %b want 0", bus.mem_req); else passed++;
    checks++; if (bus.out_valid !== 1'b1 || bus.fifo_full !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL credit_state got v=%b full=%b err=%b want 1 0 0", bus.out_valid, bus.fifo_full, bus.err); else passed++;
    bus.out_ready = 1'b1;
    checks++; if (bus.out_data !== exp_q[0]) $display("FAIL credit_first got %h want %h", bus.out_data, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
    step();
    bus.out_ready = 1'b0;
    repeat (6) step();
    checks++; if (ack_cnt != 17 || bus.mem_req !== 1'b0)
      $display("FAIL credit_one_more got acks=%0d req=%b want 17 0", ack_cnt, bus.mem_req); else passed++;
    drain("credit", 300);
  endtask

  task automatic test_backpressure();
    logic [25:0] addrs[18];
    int cnt;
    do_reset();
    for (int i = 0; i < 18; i++) addrs[i] = rand_addr();
    for (int i = 0; i < 14; i++) begin
      bus.in_read = 1'b1; bus.in_addr = addrs[i];
      exp_q.push_back(fdata(addrs[i]));
      step();
      cnt = (i == 0) ? 1 : i;
      checks++; if (bus.fifo_full !== (cnt >= 13))
        $display("FAIL bp_full_%0d got %b want %b", i, bus.fifo_full, cnt >= 13); else passed++;
    end
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== addrs[0])
      $display("FAIL bp_held got req=%b addr=%h want 1 %h", bus.mem_req, bus.mem_addr, addrs[0]); else passed++;
    for (int i = 14; i < 18; i++) begin
      bus.in_read = 1'b1; bus.in_addr = addrs[i];
      if (i < 17) exp_q.push_back(fdata(addrs[i]));
      step();
      checks++; if (bus.err !== (i == 17))
        $display("FAIL bp_err_%0d got %b want %b", i, bus.err, i == 17); else passed++;
    end
    bus.in_read = 1'b0;
    checks++; if (bus.fifo_full !== 1'b1 || bus.mem_addr !== addrs[0])
      $display("FAIL bp_final got full=%b addr=%h want 1 %h", bus.fifo_full, bus.mem_addr, addrs[0]); else passed++;
    drain("bp", 400);
    checks++; if (bus.err !== 1'b1) $display("FAIL bp_err_sticky got %b want 1", bus.err); else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.in_read = 1'b1; bus.in_addr = 26'h0000040;
    step();
    bus.in_addr = 26'h0000044;
    step();
    bus.in_read = 1'b0; bus.mem_ack = 1'b1;
    step();
    step();
    bus.mem_ack = 1'b0;
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'h11;
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11)
      $display("FAIL simul_first got v=%b d=%h want 1 11", bus.out_valid, bus.out_data); else passed++;
    bus.mem_rdata = 32'h22; bus.out_ready = 1'b1;
    step();
    bus.mem_rdata_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h22)
      $display("FAIL simul_swap got v=%b d=%h want 1 22", bus.out_valid, bus.out_data); else passed++;
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.idle !== 1'b1 || bus.err !== 1'b0)
      $display("FAIL simul_count got v=%b idle=%b err=%b want 0 1 0", bus.out_valid, bus.idle, bus.err); else passed++;
  endtask

  task automatic test_stray();
    do_reset();
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'h55;
    step();
    bus.mem_rdata_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.err !== 1'b1)
      $display("FAIL stray got v=%b err=%b want 0 1", bus.out_valid, bus.err); else passed++;
    do_reset();
    checks++; if (bus.err !== 1'b0) $display("FAIL stray_clear got %b want 0", bus.err); else passed++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_read = 1'b1; bus.in_addr = rand_addr();
      step();
    end
    bus.in_read = 1'b0;
    repeat (3) step();
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'(k + 1);
      step();
    end
    bus.mem_rdata_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.idle !== 1'b0)
      $display("FAIL midop_busy got v=%b idle=%b want 1 0", bus.out_valid, bus.idle); else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.idle !== 1'b1 || bus.err !== 1'b0)
      $display("FAIL midop_reset got v=%b req=%b idle=%b err=%b want 0 0 1 0",
               bus.out_valid, bus.mem_req, bus.idle, bus.err); else passed++;
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'h4;
    step();
    bus.mem_rdata_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.err !== 1'b1)
      $display("FAIL midop_stray got v=%b err=%b want 0 1", bus.out_valid, bus.err); else passed++;
  endtask

  task automatic test_random();
    logic [25:0] a;
    int pops = 0;
    do_reset();
    resp_rate = 60; resp_en = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (ack_cnt - pops > 16 || ack_cnt - pops < 0)
        $display("FAIL rand_credit got outstanding=%0d want 0..16", ack_cnt - pops); else passed++;
      bus.out_ready = 1'($urandom_range(1));
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL rand_extra got %h want no data", bus.out_data);
        else if (bus.out_data !== exp_q[0]) $display("FAIL rand_data got %h want %h", bus.out_data, exp_q[0]);
        else passed++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pops++;
      end
      bus.mem_ack = 1'($urandom_range(1));
      if (!bus.fifo_full && $urandom_range(1) == 1) begin
        a = rand_addr();
        exp_q.push_back(fdata(a));
        bus.in_read = 1'b1; bus.in_addr = a;
      end else begin
        bus.in_read = 1'b0;
      end
      step();
    end
    drain("rand", 500);
    checks++; if (bus.err !== 1'b0) $display("FAIL rand_err got %b want 0", bus.err); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit_limit();
    test_backpressure();
    test_simultaneous();
    test_stray();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish before 500000");
    $fatal(1);
  end
endmodule
